slave_serial_port: RTL

SLAVE_SERIAL_PORT -- requirements
Module: slave_serial_port

---
 rtl/slave_serial_port_pkg.sv | 21 ++
 rtl/slave_serial_port_serial_shift_reg.sv | 33 +++
 rtl/slave_serial_port.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/slave_serial_port_pkg.sv
// Shared serial bus definitions: default frame widths and the slave port state encoding.
package slave_serial_port_pkg;

  localparam int SSP_ADDR_WIDTH = 12;
  localparam int SSP_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WDATA  = 3'd2,
    ST_MWRITE = 3'd3,
    ST_RREQ   = 3'd4,
    ST_RWAIT  = 3'd5,
    ST_TX     = 3'd6
  } ssp_state_e;

  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_serial_port_serial_shift_reg.sv
// Shift register: serial input enters at the MSB so LSB-first streams land in order;
// parallel load has priority, and the serial output is always bit 0.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             shift_in,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load_en) begin
      q_d = load_data;
    end else if (shift_en) begin
      q_d = (q_q >> 1) | (WIDTH'(shift_in) << (WIDTH - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/slave_serial_port.sv
// Slave side of the serial memory bus: collects address/write data bit-serially,
// issues single-cycle memory strobes and streams read data back LSB first.
module slave_serial_port
  import slave_serial_port_pkg::*;
#(
  parameter int ADDR_WIDTH = SSP_ADDR_WIDTH,
  parameter int DATA_WIDTH = SSP_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int               CNT_W     = $clog2(max_width(ADDR_WIDTH, DATA_WIDTH) + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  ssp_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic                  live_q, live_d;
  logic                  addr_shift, wdata_shift, rdata_load, rdata_shift;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  unused_rdata_hi;

  // live_q keeps sready low while reset is held and until the first edge after release
  assign live_d = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      live_q  <= live_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    addr_shift  = 1'b0;
    wdata_shift = 1'b0;
    rdata_load  = 1'b0;
    rdata_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (live_q && mvalid) begin
          addr_shift = 1'b1;
          mode_d     = smode;
          state_d    = ST_ADDR;
          cnt_d      = CNT_W'(1);
        end
      end
      ST_ADDR: begin
        if (mvalid) begin
          addr_shift = 1'b1;
          if (cnt_q == ADDR_LAST) begin
            state_d = mode_q ? ST_WDATA : ST_RREQ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WDATA: begin
        if (mvalid) begin
          wdata_shift = 1'b1;
          if (cnt_q == DATA_LAST) begin
            state_d = ST_MWRITE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_MWRITE: state_d = ST_IDLE;
      ST_RREQ:   state_d = ST_RWAIT;
      ST_RWAIT: begin
        if (mem_rvalid) begin
          rdata_load = 1'b1;
          state_d    = ST_TX;
        end
      end
      ST_TX: begin
        rdata_shift = 1'b1;
        if (cnt_q == DATA_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  serial_shift_reg #(.WIDTH(ADDR_WIDTH)) u_addr_sr (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (addr_shift),
    .shift_in  (swdata),
    .load_en   (1'b0),
    .load_data ('0),
    .q         (mem_addr)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_wdata_sr (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (wdata_shift),
    .shift_in  (swdata),
    .load_en   (1'b0),
    .load_data ('0),
    .q         (mem_wdata)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_rdata_sr (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (rdata_shift),
    .shift_in  (1'b0),
    .load_en   (rdata_load),
    .load_data (mem_rdata),
    .q         (rdata_q)
  );

  // only bit 0 is ever transmitted; the upper bits just ripple down behind it
  assign unused_rdata_hi = ^rdata_q[DATA_WIDTH-1:1];

  assign sready  = live_q && (state_q == ST_IDLE);
  assign svalid  = (state_q == ST_TX);
  assign srdata  = svalid & rdata_q[0];
  assign mem_wen = (state_q == ST_MWRITE);
  assign mem_ren = (state_q == ST_RREQ);

endmodule
